// File: rtl/uart_pkg.sv
// Shared definitions for the UART echo-path line buffer.
package uart_pkg;

  // Buffer state as seen by the transmitter side.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HOLD  = 2'd1,
    ST_DRAIN = 2'd2
  } status_e;

  // Carriage return ends a line.
  localparam logic [7:0] UART_EOL = 8'h0D;

  // Width of a counter able to hold 0..depth inclusive.
  function automatic int level_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/uart_idle_timer.sv
// Counts cycles without a push while unreleased bytes are waiting; expired
// rises once the line has been quiet for IDLE_TIMEOUT cycles.
module uart_idle_timer #(
  parameter int unsigned IDLE_TIMEOUT = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic run,
  output logic expired
);

  generate
    if (IDLE_TIMEOUT == 0) begin : g_off
      // Timeout disabled: the inputs are intentionally ignored.
      logic unused_inputs;
      assign unused_inputs = ^{clk, rst_n, clear, run};
      assign expired = 1'b0;
    end else begin : g_on
      // The counter reads 0 in the first cycle after a push, so reaching
      // IDLE_TIMEOUT-1 means IDLE_TIMEOUT quiet cycles have elapsed.
      localparam int unsigned LIMIT = IDLE_TIMEOUT - 1;
      localparam int CW = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;

      logic [CW-1:0] cnt;

      // Saturating idle counter, restarted by every push.
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values of its inputs.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt <= '0;
        end else if (clear) begin
          cnt <= '0;
        end else if (run && (cnt != CW'(LIMIT))) begin
          cnt <= cnt + CW'(1);
        end
      end

      assign expired = run && (cnt == CW'(LIMIT));
    end
  endgenerate

endmodule

// File: rtl/uart_line_buffer.sv
// Byte buffer between UART receiver and transmitter. Bytes are stored on
// receive strobes and released to the valid/ready output either per byte or
// per line (end-of-line byte, full buffer or idle timeout).
module uart_line_buffer
  import uart_pkg::*;
#(
  parameter int          DEPTH        = 16,
  parameter bit          LINE_MODE    = 1'b1,
  parameter logic [7:0]  EOL_BYTE     = UART_EOL,
  parameter int unsigned IDLE_TIMEOUT = 1_000_000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [7:0]                in_data,
  input  logic                      in_valid,
  output logic [7:0]                out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  input  logic                      clr_overflow,
  output logic                      overflow,
  output logic [level_w(DEPTH)-1:0] level,
  output logic [1:0]                status
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = level_w(DEPTH);
  localparam logic [LW-1:0] FULL = LW'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr, rel_ptr;
  logic [LW-1:0] count, rel_count;

  logic          pop, push, drop, is_eol, do_release, timer_expired;
  logic [PW-1:0] wr_ptr_nx;
  logic [LW-1:0] count_nx, rel_count_nx;
  status_e       st;

  // Released bytes sit between rd_ptr and rel_ptr; equal pointers with a
  // full released count means the whole buffer is released.
  assign out_valid = (rd_ptr != rel_ptr) || (rel_count == FULL);
  assign out_data  = out_valid ? mem[rd_ptr] : 8'h00;
  assign level     = count;
  assign status    = st;

  // Handshake decode and release decision for the current cycle.
  // NOTE: every always_comb output gets a value on every path (defaults or
  // full assignment) so no latch is inferred.
  always_comb begin
    pop       = out_valid && out_ready;
    push      = in_valid && ((count != FULL) || pop);
    drop      = in_valid && !push;
    is_eol    = (in_data == EOL_BYTE);
    wr_ptr_nx = wr_ptr + PW'(push);
    count_nx  = count + LW'(push) - LW'(pop);
    // A push this cycle restarts the idle window, so the timeout yields to it.
    do_release = (push && (!LINE_MODE || is_eol || (count_nx == FULL)))
              || (drop && is_eol)
              || (timer_expired && !push);
    rel_count_nx = do_release ? count_nx : (rel_count - LW'(pop));
  end

  // Buffer state derived from the two counts.
  always_comb begin
    st = ST_DRAIN;
    if (count == '0) begin
      st = ST_IDLE;
    end else if (rel_count == '0) begin
      st = ST_HOLD;
    end
  end

  uart_idle_timer #(
    .IDLE_TIMEOUT(IDLE_TIMEOUT)
  ) u_idle_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (push),
    .run     (count != rel_count),
    .expired (timer_expired)
  );

  // Storage, pointers, counts and sticky overflow.
  // NOTE: the storage array is reset too, so out_data is fully defined from
  // reset onward; this costs a reset net per storage bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 8'h00;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      rel_ptr   <= '0;
      count     <= '0;
      rel_count <= '0;
      overflow  <= 1'b0;
    end else begin
      if (push) mem[wr_ptr] <= in_data;
      wr_ptr <= wr_ptr_nx;
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      if (do_release) rel_ptr <= wr_ptr_nx;
      count     <= count_nx;
      rel_count <= rel_count_nx;
      if (drop) begin
        overflow <= 1'b1;
      end else if (clr_overflow) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: doc/uart_line_buffer.md
# uart_line_buffer

Byte buffer between the UART receiver and transmitter of the echo path. It accepts single-cycle receive strobes, stores up to DEPTH bytes and drains them through a valid/ready handshake into the transmitter. In line mode it holds bytes until an end-of-line byte arrives, the buffer fills, or the line goes idle. Lines are then echoed whole instead of byte-by-byte.

## Interface
- DEPTH, 16: storage in bytes; power of two, ≥ 2.
- LINE_MODE, 1: 1 = hold bytes until release; 0 = release every byte as soon as it is stored.
- EOL_BYTE, 8'h0D: byte value that triggers a release.
- IDLE_TIMEOUT, 1_000_000: clock cycles without a push before held bytes are released; 0 disables the timeout.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_data  in  8  received byte.
- in_valid  in  1  one-cycle strobe from the receiver; there is no backpressure.
- out_data  out  8  head byte; 8'h00 whenever out_valid = 0.
- out_valid  out  1  a released byte is available.
- out_ready  in  1  transmitter accepts the byte.
- clr_overflow  in  1  one-cycle pulse that clears overflow.
- overflow  out  1  sticky: a byte was dropped.
- level  out  $clog2(DEPTH)+1  stored byte count.
- status  out  2  0 = IDLE, 1 = HOLD, 2 = DRAIN.

## Operation
- Pointers: wr_ptr, rd_ptr, rel_ptr, each $clog2(DEPTH) bits, wrapping modulo DEPTH. The count is a separate register.
- Push:
  - A push occurs when in_valid = 1 and (count < DEPTH or a pop occurs in the same cycle).
  - When count == DEPTH and no pop occurs, the byte is dropped and overflow is set.
- Pop: a pop occurs when out_valid = 1 and out_ready = 1.
- Release moves rel_ptr to the post-push wr_ptr. It is triggered by any of:
  - LINE_MODE = 0: every push.
  - A push of EOL_BYTE.
  - A dropped EOL_BYTE, which releases all stored bytes.
  - count reaching DEPTH after a push.
  - The idle counter expiring.
- out_valid = (rd_ptr != rel_ptr) or (count == DEPTH and all bytes are released). The released-byte count is tracked explicitly so that the full case is unambiguous.
- Once out_valid is high, out_data holds steady until the pop.
- Idle counter:
  - Cleared on every push.
  - Counts only while unreleased bytes exist.
  - Saturates at expiry.
- status: IDLE when count = 0; HOLD when count > 0 and no byte is released; DRAIN when at least one byte is released.
- overflow:
  - Set on a drop; cleared by clr_overflow.
  - A drop in the same cycle as clr_overflow leaves overflow set.
- Reset (asynchronous, takes effect immediately, including mid-drain):
  - Pointers, count, released count, idle counter, overflow and storage all go to 0.
  - out_valid = 0, out_data = 8'h00, level = 0, status = IDLE.

## Timing
- Push at cycle N: level updates at N+1.
  - A releasing push (EOL, full, or LINE_MODE = 0) gives out_valid = 1 at N+1.
- Throughput: one pop per cycle. With out_ready held high, consecutive released bytes appear on consecutive cycles.
- Pop at cycle N: the next byte, or out_valid = 0, appears at N+1.
- Timeout: with the last push at cycle N and no release, out_valid rises at N+IDLE_TIMEOUT+1.
- Push and pop in the same cycle: level is unchanged, and ordering is preserved.
- Push of EOL while out_ready = 0: the release is still recorded, and draining continues once out_ready returns.
- The outputs derive only from registers; there is no combinational path from in_valid to out_valid.

## Structure
- Package uart_pkg holds:
  - The status encoding enum.
  - The EOL constant (8'h0D).
  - The level-width function.
- Sub-module uart_idle_timer holds the idle counter. Its ports are clk, rst_n, clear, run and expired; it takes IDLE_TIMEOUT as a parameter, and 0 disables it.
- Storage is an in-module register array with asynchronous reset.

## Test plan
- LINE_MODE = 1; push 8'h41, 8'h42, 8'h0D; out_ready = 1 → status = HOLD after 8'h41, then out_data 41, 42, 0D on three consecutive cycles starting the cycle after 8'h0D is pushed; level returns to 0 and status to IDLE.
- Same line with out_ready = 0 for 5 cycles after release → out_valid = 1, out_data stays 8'h41 and level stays 3; drain completes after out_ready rises.
- DEPTH = 16; push 16 non-EOL bytes → forced release, level = 16; a 17th push with out_ready = 0 → dropped, overflow = 1, level stays 16; clr_overflow → overflow = 0.
- IDLE_TIMEOUT = 100; push 8'h55 at cycle N → out_valid stays 0 through N+100 and rises at N+101 with out_data = 8'h55.
- Full buffer with push of 8'h77 and pop in the same cycle → push accepted, level stays 16, overflow stays 0; 8'h77 is the last byte drained.
- Assert rst_n low mid-drain → out_valid = 0 and level = 0 with no clock edge; after release, LINE_MODE = 0 and a push of 8'h31 → out_valid = 1 the next cycle with out_data = 8'h31.
